// File: rtl/dptr_pkg.sv
// Shared constants for the dptr_rtype R-type datapath: field widths,
// opcode/funct encodings and a helper that says which functs the ALU implements.
package dptr_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = $clog2(REG_COUNT);

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  function automatic logic funct_supported(input logic [5:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_AND) ||
           (funct == FUNCT_OR)  || (funct == FUNCT_NOR) || (funct == FUNCT_SLT);
  endfunction

endpackage

// File: rtl/dptr_regfile.sv
// Register file: two combinational read ports, one rising-edge write port.
// Async active-low reset loads R[i] = i; register 0 always reads as zero.
module dptr_regfile #(
  parameter int DATA_W    = dptr_pkg::DATA_W,
  parameter int REG_COUNT = dptr_pkg::REG_COUNT,
  parameter int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];

  // Reset wins over a write arriving on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/dptr_rtype.sv
// Single-cycle R-type datapath: decodes one instruction per clock, reads rs/rt,
// computes the ALU result combinationally and writes it to rd on the rising edge.
module dptr_rtype #(
  parameter int DATA_W    = dptr_pkg::DATA_W,
  parameter int REG_COUNT = dptr_pkg::REG_COUNT
) (
  input  logic              clk_dtpr,
  input  logic              rst_n_dtpr,
  input  logic [31:0]       instruccion,
  output logic              ZF_DPTR,
  output logic [DATA_W-1:0] alu_result_dptr
);
  import dptr_pkg::*;

  localparam int AW = $clog2(REG_COUNT);

  logic [5:0]        opcode;
  logic [AW-1:0]     rs, rt, rd;
  logic [5:0]        funct;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] alu_d;
  logic              we;
  logic              unused_shamt;

  assign opcode = instruccion[31:26];
  assign rs     = instruccion[25:21];
  assign rt     = instruccion[20:16];
  assign rd     = instruccion[15:11];
  assign funct  = instruccion[5:0];
  assign unused_shamt = ^instruccion[10:6];

  dptr_regfile #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clk_i     (clk_dtpr),
    .rst_ni    (rst_n_dtpr),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (op_a),
    .rdata_b_o (op_b),
    .we_i      (we),
    .waddr_i   (rd),
    .wdata_i   (alu_d)
  );

  // The ALU evaluates funct regardless of opcode; only the write is gated.
  always_comb begin
    alu_d = '0;
    case (funct)
      FUNCT_ADD: alu_d = op_a + op_b;
      FUNCT_SUB: alu_d = op_a - op_b;
      FUNCT_AND: alu_d = op_a & op_b;
      FUNCT_OR:  alu_d = op_a | op_b;
      FUNCT_NOR: alu_d = ~(op_a | op_b);
      FUNCT_SLT: alu_d = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default:   alu_d = '0;
    endcase
  end

  assign we = (opcode == OPCODE_RTYPE) && funct_supported(funct) && (rd != '0);

  assign alu_result_dptr = alu_d;
  assign ZF_DPTR         = (alu_d == '0);

endmodule

// File: tb/tb_dptr_rtype.sv
// Self-checking bench for dptr_rtype: a register-array reference model checked on
// every falling edge, plus directed sequences with hand-computed expectations.
module tb_dptr_rtype;

  logic        clk_dtpr;
  logic        rst_n_dtpr;
  logic [31:0] instruccion;
  logic        ZF_DPTR;
  logic [31:0] alu_result_dptr;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 0;

  logic [31:0] model_r [32];

  dptr_rtype dut (
    .clk_dtpr        (clk_dtpr),
    .rst_n_dtpr      (rst_n_dtpr),
    .instruccion     (instruccion),
    .ZF_DPTR         (ZF_DPTR),
    .alu_result_dptr (alu_result_dptr)
  );

  // ---------------- clock ----------------
  initial clk_dtpr = 1'b0;
  always #5 clk_dtpr = ~clk_dtpr;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] funct);
    logic [31:0] w;
    w = 32'h0;
    w[25:21] = 5'(rs);
    w[20:16] = 5'(rt);
    w[15:11] = 5'(rd);
    w[5:0]   = funct;
    return w;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : model_r[idx];
  endfunction

  function automatic longint to_signed(input logic [31:0] v);
    return v[31] ? (longint'(v) - 64'sh1_0000_0000) : longint'(v);
  endfunction

  function automatic logic [31:0] model_result(input logic [31:0] ins);
    logic [31:0] a, b;
    a = model_read(ins[25:21]);
    b = model_read(ins[20:16]);
    case (ins[5:0])
      6'd32:   return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      6'd34:   return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd39:   return ~(a | b);
      6'd42:   return (to_signed(a) < to_signed(b)) ? 32'd1 : 32'd0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_writes(input logic [31:0] ins);
    bit known;
    known = (ins[5:0] inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42});
    return (ins[31:26] == 6'd0) && known && (ins[15:11] != 5'd0);
  endfunction

  always @(posedge clk_dtpr or negedge rst_n_dtpr) begin
    if (!rst_n_dtpr) begin
      for (int i = 0; i < 32; i++) model_r[i] = 32'(i);
    end else if (model_writes(instruccion)) begin
      model_r[instruccion[15:11]] = model_result(instruccion);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_dtpr) begin
    if (check_en) begin
      logic [31:0] exp_res;
      exp_res = model_result(instruccion);
      n_tests++;
      if (alu_result_dptr !== exp_res || ZF_DPTR !== (exp_res == 32'h0)) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t ins=%08h: got res=%08h zf=%b, want res=%08h zf=%b",
                 $time, instruccion, alu_result_dptr, ZF_DPTR, exp_res, exp_res == 32'h0);
      end
    end
  end

  // ---------------- driver / literal checks ----------------
  task automatic drive(input logic [31:0] ins);
    @(posedge clk_dtpr);
    #1 instruccion = ins;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] exp_res);
    logic exp_zf;
    exp_zf = (exp_res == 32'h0);
    n_tests++;
    if (alu_result_dptr !== exp_res || ZF_DPTR !== exp_zf) begin
      n_fail++;
      $display("FAIL %s: got res=%08h zf=%b, want res=%08h zf=%b",
               name, alu_result_dptr, ZF_DPTR, exp_res, exp_zf);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_dtpr);
    #2 rst_n_dtpr = 1'b0;
    instruccion = 32'h0;
    #10 rst_n_dtpr = 1'b1;
  endtask

  // read R[r] through "or $0,$r,$0" (no write since rd = 0)
  task automatic read_reg(input string name, input int r, input logic [31:0] exp_val);
    drive(rtype(r, 0, 0, 6'b100101));
    check(name, exp_val);
  endtask

  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR  = 6'b100101, F_NOR = 6'b100111, F_SLT = 6'b101010;

  initial begin
    rst_n_dtpr  = 1'b1;
    instruccion = 32'h0;
    #3 rst_n_dtpr = 1'b0;
    #1 check_en = 1;
    check("reset_nop", 32'h0);
    #10 rst_n_dtpr = 1'b1;

    // 1: add $1,$2,$3
    drive(32'h0043_0820);
    check("add_1_2_3", 32'd5);
    read_reg("r1_after_add", 1, 32'd5);

    // 2: sequence with NOPs
    do_reset();
    drive(rtype(15, 9, 20, F_SUB));  check("sub_20_15_9", 32'd6);
    drive(32'h0);                    check("nop_a", 32'h0);
    drive(rtype(20, 9, 20, F_SUB));  check("sub_20_20_9", 32'hFFFF_FFFD);
    drive(32'h0);                    check("nop_b", 32'h0);
    drive(rtype(5, 15, 15, F_ADD));  check("add_15_5_15", 32'd20);
    drive(32'h0);                    check("nop_c", 32'h0);
    drive(rtype(9, 15, 15, F_ADD));  check("add_15_9_15", 32'd29);
    drive(32'h0);                    check("nop_d", 32'h0);
    drive(rtype(20, 15, 21, F_SLT)); check("slt_21_20_15", 32'd1);
    read_reg("r20_final", 20, 32'hFFFF_FFFD);

    // 3: zero flag and logic ops
    drive(rtype(7, 7, 3, F_SUB));    check("sub_3_7_7", 32'h0);
    read_reg("r3_zero", 3, 32'h0);
    drive(rtype(12, 10, 22, F_AND)); check("and_12_10", 32'd8);
    drive(rtype(12, 10, 23, F_OR));  check("or_12_10", 32'd14);
    drive(rtype(12, 10, 24, F_NOR)); check("nor_12_10", 32'hFFFF_FFF1);

    // 4: boundaries
    drive(rtype(31, 31, 0, F_ADD));  check("add_to_r0", 32'd62);
    read_reg("r0_stays_0", 0, 32'h0);
    drive(rtype(1, 1, 29, F_ADD));   check("double_seed", 32'd2);
    for (int i = 0; i < 30; i++) drive(rtype(29, 29, 29, F_ADD));
    read_reg("r29_msb", 29, 32'h8000_0000);
    drive(rtype(29, 0, 31, F_NOR));  check("nor_to_max", 32'h7FFF_FFFF);
    drive(rtype(31, 1, 28, F_ADD));  check("add_wrap", 32'h8000_0000);
    drive(rtype(28, 1, 27, F_SLT));  check("slt_neg_lt_1", 32'd1);
    drive(rtype(1, 28, 26, F_SLT));  check("slt_1_lt_neg", 32'd0);

    // 5: unsupported funct and non-R opcode
    do_reset();
    drive(rtype(1, 2, 4, 6'b000011)); check("funct_03", 32'h0);
    read_reg("r4_unwritten", 4, 32'd4);
    drive(rtype(1, 2, 5, F_ADD) | 32'h1000_0000); check("opc_04_add", 32'd3);
    read_reg("r5_unwritten", 5, 32'd5);

    // random R-type traffic (model-checked every cycle)
    for (int i = 0; i < 200; i++) begin
      logic [5:0] f;
      logic [31:0] ins;
      case ($urandom_range(0, 7))
        0: f = F_ADD; 1: f = F_SUB; 2: f = F_AND; 3: f = F_OR;
        4: f = F_NOR; 5: f = F_SLT; 6: f = 6'($urandom_range(0, 63));
        default: f = 6'b000000;
      endcase
      ins = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), f);
      if ($urandom_range(0, 9) == 0) ins[31:26] = 6'($urandom_range(1, 63));
      ins[10:6] = 5'($urandom_range(0, 31));
      drive(ins);
    end

    // 6: reset mid-run
    do_reset();
    drive(rtype(1, 2, 6, F_ADD));    check("add_6_1_2", 32'd3);
    drive(rtype(6, 0, 0, F_OR));     check("r6_before_rst", 32'd3);
    rst_n_dtpr = 1'b0;
    #1 check("r6_async_rst", 32'd6);
    instruccion = rtype(1, 1, 7, F_ADD);
    #1 check("add_in_rst", 32'd2);
    @(posedge clk_dtpr);
    #2 instruccion = rtype(7, 0, 0, F_OR);
    #1 check("r7_held_rst", 32'd7);
    rst_n_dtpr = 1'b1;
    read_reg("r7_after_rst", 7, 32'd7);

    @(posedge clk_dtpr);
    #1 check_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
